// File: rtl/game_ctrl.sv
// Tetris front end: button sync/debounce, gravity timer, LFSR block picker,
// score accumulation and the IDLE/PLAY/OVER game state machine.
module game_ctrl #(
  parameter int          DEBOUNCE = 16,
  parameter int          GRAVITY  = 25000000,
  parameter int          CNT_W    = 26,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        btn_rot,
  input  logic        btn_start,
  input  logic        next_block,
  input  logic        gameover,
  input  logic [9:0]  score_plus,
  output logic        left,
  output logic        right,
  output logic        down,
  output logic [9:0]  ro,
  output logic [9:0]  block_num,
  output logic [15:0] score,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2, BAD = 2'd3} st_t;

  localparam int NB  = 5;
  localparam int DW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int BL  = 0;
  localparam int BR  = 1;
  localparam int BD  = 2;
  localparam int BRO = 3;
  localparam int BS  = 4;

  st_t                  st;
  logic [NB-1:0]        raw, sync1, sync2, lvl, rise;
  logic [NB-1:0][DW-1:0] dcnt;
  logic [3:0]           pend;
  logic [15:0]          lfsr;
  logic [CNT_W-1:0]     gcnt;
  logic [2:0]           pick;
  logic [16:0]          sum;
  logic                 grav_tick;

  assign state = st;
  assign raw   = {btn_start, btn_rot, btn_down, btn_right, btn_left};

  // A rise is reported on the same edge the debounced level flips to 1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < NB; i++)
      rise[i] = sync2[i] & ~lvl[i] & (dcnt[i] == DW'(DEBOUNCE - 1));
  end

  always_comb begin
    pick = 3'd0;
    if (lfsr[2:0] != 3'd7)      pick = lfsr[2:0];
    else if (lfsr[5:3] != 3'd7) pick = lfsr[5:3];
  end

  assign sum       = {1'b0, score} + {7'd0, score_plus};
  assign grav_tick = (gcnt == CNT_W'(GRAVITY - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      dcnt  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != lvl[i]) begin
          if (dcnt[i] == DW'(DEBOUNCE - 1)) begin
            lvl[i]  <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      left      <= 1'b0;
      right     <= 1'b0;
      down      <= 1'b0;
      ro        <= '0;
      block_num <= '0;
      score     <= '0;
      lfsr      <= SEED;
      gcnt      <= '0;
      pend      <= '0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      left  <= 1'b0;
      right <= 1'b0;
      down  <= 1'b0;
      ro    <= '0;
      // Servicing a flag overrides a press landing on the same edge.
      pend  <= pend | rise[3:0];
      case (st)
        IDLE: begin
          pend <= '0;
          if (rise[BS]) begin
            st        <= PLAY;
            block_num <= {7'd0, pick};
            score     <= '0;
            gcnt      <= '0;
          end
        end
        PLAY: begin
          if (gameover) begin
            st <= OVER;
          end else if (next_block) begin
            block_num <= {7'd0, pick};
            score     <= sum[16] ? 16'hFFFF : sum[15:0];
            gcnt      <= '0;
          end else if (grav_tick || pend[BD]) begin
            down     <= 1'b1;
            gcnt     <= '0;
            pend[BD] <= 1'b0;
          end else if (pend[BRO]) begin
            ro        <= 10'd1;
            pend[BRO] <= 1'b0;
          end else if (pend[BL]) begin
            left     <= 1'b1;
            pend[BL] <= 1'b0;
          end else if (pend[BR]) begin
            right    <= 1'b1;
            pend[BR] <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        OVER: begin
          if (rise[BS]) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: rule-level reference model checked every cycle,
// plus literal expectations for latency, priority, scoring and reset.
module tb_game_ctrl;
  localparam int D = 4;
  localparam int G = 1000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        btn_left = 0, btn_right = 0, btn_down = 0, btn_rot = 0, btn_start = 0;
  logic        next_block = 0, gameover = 0;
  logic [9:0]  score_plus = '0;
  logic        left, right, down;
  logic [9:0]  ro, block_num;
  logic [15:0] score;
  logic [1:0]  state;

  game_ctrl #(.DEBOUNCE(D), .GRAVITY(G), .CNT_W(10), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .btn_rot(btn_rot), .btn_start(btn_start),
    .next_block(next_block), .gameover(gameover), .score_plus(score_plus),
    .left(left), .right(right), .down(down), .ro(ro),
    .block_num(block_num), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: states 0/1/2, plain integer score with saturation,
  // debounced level flips once the last D synchronized samples all disagree.
  bit          mvalid = 0;
  int          m_state, m_blk, m_score, m_gcnt, pk;
  bit          m_left, m_right, m_down, m_ro, allfl, was_idle;
  bit   [15:0] m_lfsr;
  bit   [3:0]  m_pend, serv;
  bit   [4:0]  m_lvl, rs, rawv;
  bit   [4:0]  h [6];

  always @(posedge clk) begin
    if (!rst_n) begin
      mvalid = 1; m_state = 0; m_blk = 0; m_score = 0; m_gcnt = 0;
      m_left = 0; m_right = 0; m_down = 0; m_ro = 0;
      m_lfsr = 16'hACE1; m_pend = 0; m_lvl = 0;
      for (int j = 0; j < 6; j++) h[j] = 0;
    end else begin
      rawv = {btn_start, btn_rot, btn_down, btn_right, btn_left};
      for (int j = 5; j > 0; j--) h[j] = h[j-1];
      h[0] = rawv;
      rs = 0;
      for (int b = 0; b < 5; b++) begin
        allfl = 1;
        for (int j = 2; j < 2 + D; j++) if (h[j][b] == m_lvl[b]) allfl = 0;
        if (allfl) begin
          m_lvl[b] = ~m_lvl[b];
          if (m_lvl[b]) rs[b] = 1;
        end
      end
      pk = (m_lfsr[2:0] != 3'd7) ? int'(m_lfsr[2:0]) :
           (m_lfsr[5:3] != 3'd7) ? int'(m_lfsr[5:3]) : 0;
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      m_left = 0; m_right = 0; m_down = 0; m_ro = 0; serv = 0;
      was_idle = (m_state == 0);
      case (m_state)
        0: if (rs[4]) begin m_state = 1; m_blk = pk; m_score = 0; m_gcnt = 0; end
        1: begin
          if (gameover) m_state = 2;
          else if (next_block) begin
            m_blk = pk;
            m_score = (m_score + int'(score_plus) > 65535) ? 65535 : m_score + int'(score_plus);
            m_gcnt = 0;
          end
          else if (m_gcnt == G - 1 || m_pend[2]) begin m_down = 1; m_gcnt = 0; serv[2] = 1; end
          else if (m_pend[3]) begin m_ro = 1; serv[3] = 1; end
          else if (m_pend[0]) begin m_left = 1; serv[0] = 1; end
          else if (m_pend[1]) begin m_right = 1; serv[1] = 1; end
          else m_gcnt++;
        end
        default: if (rs[4]) m_state = 0;
      endcase
      for (int k = 0; k < 4; k++)
        m_pend[k] = (was_idle || serv[k]) ? 1'b0 : (m_pend[k] | rs[k]);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("left", {31'd0, left}, {31'd0, m_left});
      chk("right", {31'd0, right}, {31'd0, m_right});
      chk("down", {31'd0, down}, {31'd0, m_down});
      chk("ro", {22'd0, ro}, m_ro ? 32'd1 : 32'd0);
      chk("block_num", {22'd0, block_num}, m_blk);
      chk("score", {16'd0, score}, m_score);
      chk("state", {30'd0, state}, m_state);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    btn_start = 1; cyc(8); btn_start = 0; cyc(8);
  endtask

  int lat, pc, td, tr, tl, nr;

  initial begin
    cyc(2);
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_score", {16'd0, score}, 0);
    chk("rst_lfsr", {16'd0, dut.lfsr}, 32'hACE1);
    rst_n = 1;
    cyc(1);
    chk("lfsr_step1", {16'd0, dut.lfsr}, 32'h59C3);
    chk("model_lfsr_step1", {16'd0, m_lfsr}, 32'h59C3);

    press_start();
    chk("start_state", {30'd0, state}, 1);
    chk("start_blk_range", {31'd0, block_num < 10'd7}, 1);

    // Bouncy left press: stable high from the third drive onwards.
    btn_left = 1; cyc(1); btn_left = 0; cyc(1); btn_left = 1;
    lat = -1; pc = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      if (left) begin pc++; if (lat < 0) lat = c; end
    end
    chk("left_latency", lat, 7);
    chk("left_pulses", pc, 1);
    btn_left = 0; cyc(10);

    btn_right = 1; cyc(3); btn_right = 0;
    pc = 0;
    for (int c = 0; c < 15; c++) begin cyc(1); pc += int'(right); end
    chk("glitch_no_pulse", pc, 0);

    // Time rot+left so their flags are pending on the gravity tick edge.
    for (int i = 0; i < 3000 && m_gcnt != G - 7; i++) cyc(1);
    chk("gravity_wait", m_gcnt, G - 7);
    btn_rot = 1; btn_left = 1;
    td = -1; tr = -1; tl = -1; nr = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc(1);
      if (down && td < 0) td = c;
      if (ro == 10'd1 && tr < 0) tr = c;
      if (left && tl < 0) tl = c;
      nr += int'(right);
    end
    chk("prio_down", td, 7);
    chk("prio_ro", tr, 8);
    chk("prio_left", tl, 9);
    chk("prio_right", nr, 0);
    btn_rot = 0; btn_left = 0; cyc(10);

    score_plus = 10'd10;
    for (int k = 1; k <= 3; k++) begin
      next_block = 1; cyc(1); next_block = 0;
      chk("score_acc", {16'd0, score}, 10 * k);
      chk("score_blk_range", {31'd0, block_num < 10'd7}, 1);
      chk("score_no_move", {28'd0, left, right, down, ro != 10'd0}, 0);
      cyc(2);
    end
    next_block = 1; cyc(1); next_block = 0;
    chk("score_40", {16'd0, score}, 40);
    cyc(2);

    rst_n = 0; cyc(1);
    chk("midrst_score", {16'd0, score}, 0);
    chk("midrst_state", {30'd0, state}, 0);
    chk("midrst_pulses", {28'd0, left, right, down, ro != 10'd0}, 0);
    chk("midrst_lfsr", {16'd0, dut.lfsr}, 32'hACE1);
    rst_n = 1; cyc(2);

    press_start();
    next_block = 1; cyc(1); next_block = 0;
    chk("regame_score", {16'd0, score}, 10);
    gameover = 1; next_block = 1; cyc(1); gameover = 0; next_block = 0;
    chk("over_state", {30'd0, state}, 2);
    chk("over_score", {16'd0, score}, 10);
    btn_left = 1; btn_down = 1;
    pc = 0;
    for (int c = 0; c < 22; c++) begin
      if (c == 12) begin btn_left = 0; btn_down = 0; end
      cyc(1);
      pc += int'(left) + int'(down) + int'(right) + int'(ro != 10'd0);
    end
    chk("over_no_pulse", pc, 0);
    press_start();
    chk("over_to_idle", {30'd0, state}, 0);
    press_start();
    chk("idle_to_play", {30'd0, state}, 1);
    chk("new_game_score", {16'd0, score}, 0);

    score_plus = 10'd1023; next_block = 1; cyc(64);
    score_plus = 10'd48; cyc(1); next_block = 0;
    chk("score_fff0", {16'd0, score}, 32'hFFF0);
    score_plus = 10'd100; next_block = 1; cyc(1); next_block = 0;
    chk("score_sat", {16'd0, score}, 32'hFFFF);
    next_block = 1; cyc(1); next_block = 0;
    chk("score_sat_hold", {16'd0, score}, 32'hFFFF);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
